// File: rtl/csm_pkg.sv
// Shared types for the n-port shared-memory controller: result codes,
// per-port FSM states and the "no lock owner" encoding.
package csm_pkg;

  typedef enum logic [1:0] {
    ERR_OK          = 2'd0,
    ERR_LOCKED      = 2'd1,
    ERR_BAD_RELEASE = 2'd2,
    ERR_RANGE       = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_REQ   = 2'd2,
    ST_DONE  = 2'd3
  } port_state_e;

  // Owner register is wide enough for port indices 0..7 plus a distinct
  // "nobody holds the lock" value.
  localparam int                  OWNER_W    = 4;
  localparam logic [OWNER_W-1:0]  OWNER_NONE = '1;

endpackage

// File: rtl/csm_rr_arbiter.sv
// Round-robin arbiter: grants one requester per cycle, searching from the
// port after the most recently granted one (port 0 first after reset).
module csm_rr_arbiter #(
  parameter int NPORTS = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NPORTS-1:0] req,
  input  logic              advance,
  output logic [NPORTS-1:0] gnt
);

  localparam int PTR_W = $clog2(NPORTS);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gnt_idx;

  // Pick the first requester at or after ptr, wrapping around.
  always_comb begin : search
    int  idx;
    logic found;
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < NPORTS; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NPORTS) idx = idx - NPORTS;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = PTR_W'(idx);
      end
    end
  end

  // Priority pointer moves to the port after the one just granted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (advance && |req) begin
      ptr <= (gnt_idx == PTR_W'(NPORTS - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/csm_nport_ctrl.sv
// N-port shared-memory controller with a single cooperative lock.
// Each port runs IDLE -> (WDATA) -> REQ -> DONE; a round-robin arbiter
// serialises REQ ports so exactly one command executes per cycle.
// The unlock-request input is named release_req because "release" is a
// reserved word in SystemVerilog.
module csm_nport_ctrl
  import csm_pkg::*;
#(
  parameter int NPORTS   = 4,
  parameter int DATABITS = 8,
  parameter int ERRBITS  = 2,
  parameter int DEPTH    = 256
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NPORTS-1:0][DATABITS-1:0]  in_AD,
  input  logic [NPORTS-1:0]                rw,
  input  logic [NPORTS-1:0]                enable,
  input  logic [NPORTS-1:0]                hold,
  input  logic [NPORTS-1:0]                release_req,
  output logic [NPORTS-1:0]                ack,
  output logic [NPORTS-1:0]                done,
  output logic [NPORTS-1:0][ERRBITS-1:0]   err,
  output logic [NPORTS-1:0][DATABITS-1:0]  out_data
);

  localparam int PTR_W = $clog2(NPORTS);

  port_state_e          state     [NPORTS];
  port_state_e          state_nxt [NPORTS];
  logic [DATABITS-1:0]  cmd_addr  [NPORTS];
  logic [DATABITS-1:0]  cmd_wdata [NPORTS];
  logic [NPORTS-1:0]    cmd_rw;
  logic [NPORTS-1:0]    cmd_hold;
  logic [NPORTS-1:0]    cmd_rel;
  logic [NPORTS-1:0]    req;
  logic [NPORTS-1:0]    gnt;
  logic [DATABITS-1:0]  mem [DEPTH];

  logic [OWNER_W-1:0]   owner;
  logic [OWNER_W-1:0]   owner_nxt;
  logic [OWNER_W-1:0]   g_own;
  logic [PTR_W-1:0]     g_idx;
  logic                 any_gnt;
  logic [DATABITS-1:0]  g_addr;
  logic [DATABITS-1:0]  g_wdata;
  logic [DATABITS-1:0]  g_rdata;
  logic                 g_rw;
  logic                 g_hold;
  logic                 g_rel;
  logic                 in_range;
  logic                 mem_we;
  err_e                 g_err;

  csm_rr_arbiter #(.NPORTS(NPORTS)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .advance (any_gnt),
    .gnt     (gnt)
  );

  // Per-port FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NPORTS; i++) state[i] <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
      state <= state_nxt;
    end
  end

  // Per-port next-state: pure writes collect data first, everything else queues directly.
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      state_nxt[i] = state[i];
      case (state[i])
        ST_IDLE:  if (enable[i])
                    state_nxt[i] = (rw[i] && !hold[i] && !release_req[i]) ? ST_WDATA : ST_REQ;
        ST_WDATA: state_nxt[i] = ST_REQ;
        ST_REQ:   if (gnt[i]) state_nxt[i] = ST_DONE;
        ST_DONE:  state_nxt[i] = ST_IDLE;
        default:  state_nxt[i] = ST_IDLE;
      endcase
    end
  end

  // Per-port FSM outputs decoded from the current state.
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      ack[i]  = (state[i] == ST_IDLE);
      done[i] = (state[i] == ST_DONE);
      req[i]  = (state[i] == ST_REQ);
    end
  end

  // Capture the command in IDLE and the write data in WDATA.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NPORTS; i++) begin
        cmd_addr[i]  <= '0;
        cmd_wdata[i] <= '0;
      end
      cmd_rw   <= '0;
      cmd_hold <= '0;
      cmd_rel  <= '0;
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        if (state[i] == ST_IDLE && enable[i]) begin
          cmd_addr[i] <= in_AD[i];
          cmd_rw[i]   <= rw[i];
          cmd_hold[i] <= hold[i];
          cmd_rel[i]  <= release_req[i];
        end
        if (state[i] == ST_WDATA) cmd_wdata[i] <= in_AD[i];
      end
    end
  end

  // Execute the granted command: lock checks first, then range, then memory access.
  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (gnt[i]) g_idx = PTR_W'(i);
    end
    any_gnt   = |gnt;
    g_own     = OWNER_W'(g_idx);
    g_addr    = cmd_addr[g_idx];
    g_wdata   = cmd_wdata[g_idx];
    g_rw      = cmd_rw[g_idx];
    g_hold    = cmd_hold[g_idx];
    g_rel     = cmd_rel[g_idx];
    in_range  = int'(g_addr) < DEPTH;
    g_err     = ERR_OK;
    owner_nxt = owner;
    mem_we    = 1'b0;
    g_rdata   = '0;
    if (any_gnt) begin
      if (g_hold) begin
        if (owner == OWNER_NONE)  owner_nxt = g_own;
        else if (owner != g_own)  g_err     = ERR_LOCKED;
      end else if (g_rel) begin
        if (owner == g_own)       owner_nxt = OWNER_NONE;
        else                      g_err     = ERR_BAD_RELEASE;
      end else if (owner != OWNER_NONE && owner != g_own) begin
        g_err = ERR_LOCKED;
      end else if (!in_range) begin
        g_err = ERR_RANGE;
      end else if (g_rw) begin
        mem_we = 1'b1;
      end else begin
        g_rdata = mem[g_addr];
      end
    end
  end

  // Lock owner and per-port result registers, loaded on the grant edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner    <= OWNER_NONE;
      err      <= '0;
      out_data <= '0;
    end else begin
      owner <= owner_nxt;
      for (int i = 0; i < NPORTS; i++) begin
        if (gnt[i]) begin
          err[i]      <= ERRBITS'(g_err);
          out_data[i] <= g_rdata;
        end
      end
    end
  end

  // Memory write port.
  always_ff @(posedge clk) begin
    // NOTE: memory contents are deliberately not reset; only control state is.
    if (mem_we) mem[g_addr] <= g_wdata;
  end

endmodule

// File: tb/tb_csm_nport_ctrl.sv
// Directed bench for csm_nport_ctrl with an in-order completion scoreboard.
module tb_csm_nport_ctrl;

  localparam int NP    = 4;
  localparam int DB    = 8;
  localparam int EB    = 2;
  localparam int DEPTH = 200;

  localparam logic [1:0] E_OK     = 2'd0;
  localparam logic [1:0] E_LOCKED = 2'd1;
  localparam logic [1:0] E_BADREL = 2'd2;
  localparam logic [1:0] E_RANGE  = 2'd3;

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b0;
  logic [NP-1:0][DB-1:0]    in_AD = '0;
  logic [NP-1:0]            rw = '0;
  logic [NP-1:0]            enable = '0;
  logic [NP-1:0]            hold = '0;
  logic [NP-1:0]            release_req = '0;
  logic [NP-1:0]            ack;
  logic [NP-1:0]            done;
  logic [NP-1:0][EB-1:0]    err;
  logic [NP-1:0][DB-1:0]    out_data;

  typedef struct {
    int         port;
    logic [1:0] err;
    logic [7:0] data;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] mdl [256];
  int         checks = 0;
  int         errors = 0;

  csm_nport_ctrl #(.NPORTS(NP), .DATABITS(DB), .ERRBITS(EB), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_AD       (in_AD),
    .rw          (rw),
    .enable      (enable),
    .hold        (hold),
    .release_req (release_req),
    .ack         (ack),
    .done        (done),
    .err         (err),
    .out_data    (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Completion monitor: every done pulse must match the scoreboard head.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset_n) begin
      for (int p = 0; p < NP; p++) begin
        if (done[p]) begin
          if (sb_q.size() == 0) begin
            check("spurious_done", 32'(done), 32'd0);
          end else begin
            e = sb_q.pop_front();
            check("done_port", p, e.port);
            check($sformatf("err_p%0d", p), 32'(err[p]), 32'(e.err));
            check($sformatf("data_p%0d", p), 32'(out_data[p]), 32'(e.data));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $error("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    enable = '0;
  endtask

  task automatic push(int p, logic [1:0] e, logic [7:0] d);
    exp_t x;
    x.port = p;
    x.err  = e;
    x.data = d;
    sb_q.push_back(x);
  endtask

  task automatic send(int p, logic w, logic [7:0] a, logic h, logic r);
    enable[p]      = 1'b1;
    rw[p]          = w;
    in_AD[p]       = a;
    hold[p]        = h;
    release_req[p] = r;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || ack != '1) && n < 40) begin
      tick();
      n++;
    end
    check("drain_pending", sb_q.size(), 0);
  endtask

  // One command on one port, run to completion; expected data from the model.
  task automatic do_op(int p, logic w, logic h, logic r, logic [7:0] a,
                       logic [7:0] wd, logic [1:0] e_err);
    logic [7:0] e_data;
    logic       pure_wr;
    pure_wr = w && !h && !r;
    e_data  = 8'h00;
    if (!w && !h && !r && e_err == E_OK) e_data = mdl[a];
    if (pure_wr && e_err == E_OK) mdl[a] = wd;
    push(p, e_err, e_data);
    send(p, w, a, h, r);
    tick();
    if (pure_wr) in_AD[p] = wd;
    drain();
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_ack", 32'(ack), 32'hF);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();

    // Write from port 0, read back from port 3
    do_op(0, 1'b1, 1'b0, 1'b0, 8'h10, 8'hA5, E_OK);
    do_op(3, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, E_OK);

    // Uncontended read latency: accept T0, done during T1..T2
    push(2, E_OK, mdl[8'h10]);
    send(2, 1'b0, 8'h10, 1'b0, 1'b0);
    tick();
    check("lat_rd_ack_T0", 32'(ack[2]), 32'd0);
    check("lat_rd_done_T0", 32'(done[2]), 32'd0);
    tick();
    check("lat_rd_done_T1", 32'(done[2]), 32'd1);
    tick();
    check("lat_rd_done_T2", 32'(done[2]), 32'd0);
    check("lat_rd_ack_T2", 32'(ack[2]), 32'd1);
    drain();

    // Uncontended write latency: done one cycle later than a read
    mdl[8'h11] = 8'h3E;
    push(3, E_OK, 8'h00);
    send(3, 1'b1, 8'h11, 1'b0, 1'b0);
    tick();
    in_AD[3] = 8'h3E;
    tick();
    check("lat_wr_done_T1", 32'(done[3]), 32'd0);
    tick();
    check("lat_wr_done_T2", 32'(done[3]), 32'd1);
    tick();
    check("lat_wr_done_T3", 32'(done[3]), 32'd0);
    drain();

    // Simultaneous reads: two bursts, each 0,1,2,3
    for (int b = 0; b < 2; b++) begin
      for (int p = 0; p < NP; p++) begin
        push(p, E_OK, mdl[8'h10]);
        send(p, 1'b0, 8'h10, 1'b0, 1'b0);
      end
      tick();
      drain();
    end
    // Grant port 1 alone, then a burst must start at port 2
    do_op(1, 1'b0, 1'b0, 1'b0, 8'h11, 8'h00, E_OK);
    for (int k = 0; k < NP; k++) push((k + 2) % NP, E_OK, mdl[8'h11]);
    for (int p = 0; p < NP; p++) send(p, 1'b0, 8'h11, 1'b0, 1'b0);
    tick();
    drain();

    // Lock behaviour
    do_op(0, 1'b1, 1'b0, 1'b0, 8'h20, 8'h33, E_OK);
    do_op(1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, E_OK);      // port1 hold
    do_op(2, 1'b1, 1'b0, 1'b0, 8'h20, 8'h55, E_LOCKED);  // blocked write
    do_op(1, 1'b0, 1'b0, 1'b0, 8'h20, 8'h00, E_OK);      // old value 0x33
    do_op(1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, E_OK);      // owner re-hold, rw ignored
    do_op(1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, E_OK);      // release
    do_op(2, 1'b1, 1'b0, 1'b0, 8'h20, 8'h55, E_OK);      // retry
    do_op(3, 1'b0, 1'b0, 1'b0, 8'h20, 8'h00, E_OK);      // sees 0x55

    do_op(2, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, E_BADREL);  // release, no owner
    do_op(1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, E_OK);
    do_op(0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, E_LOCKED);  // hold vs owner
    do_op(0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, E_BADREL);  // non-owner release
    do_op(0, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, E_LOCKED);  // read blocked
    do_op(0, 1'b0, 1'b0, 1'b0, 8'hC8, 8'h00, E_LOCKED);  // LOCKED beats RANGE
    do_op(1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, E_OK);      // hold+release = hold
    do_op(0, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, E_LOCKED);  // still owned
    do_op(1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, E_OK);
    do_op(0, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, E_OK);

    // Address range boundary (DEPTH=200)
    do_op(2, 1'b0, 1'b0, 1'b0, 8'hC8, 8'h00, E_RANGE);
    do_op(2, 1'b1, 1'b0, 1'b0, 8'hC7, 8'h3C, E_OK);
    do_op(3, 1'b0, 1'b0, 1'b0, 8'hC7, 8'h00, E_OK);
    do_op(1, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h99, E_RANGE);

    // Reset with port0 in WDATA, port2 owning the lock, pointer at port 3
    do_op(1, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, E_OK);
    do_op(2, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, E_OK);
    send(0, 1'b1, 8'h10, 1'b0, 1'b0);
    tick();
    in_AD[0] = 8'h77;
    check("wdata_ack_low", 32'(ack[0]), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_ack", 32'(ack), 32'hF);
    check("midrst_done", 32'(done), 32'h0);
    check("midrst_err", 32'(err), 32'h0);
    @(posedge clk);
    #1;
    check("midrst_done_edge", 32'(done), 32'h0);
    reset_n = 1'b1;
    for (int p = 0; p < NP; p++) begin
      push(p, E_OK, mdl[8'h10]);
      send(p, 1'b0, 8'h10, 1'b0, 1'b0);
    end
    tick();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
